// File: rtl/shiftreg_receiver.sv
// Serial-to-parallel receiver for the shift-register generator stream: rebuilds static/dynamic words,
// checks frame length, flags protocol errors. Optional macro STAT_CHECK_EN adds the stat_mismatch output.
module shiftreg_receiver #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16
`ifdef STAT_CHECK_EN
  ,parameter logic [SIZESRSTAT-1:0] STAT_EXPECTED = 88'hABCDEF123456789ABCDEF1
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  signal_in,
  input  logic                  sel_stat,
  input  logic                  sel_dyn,
  input  logic                  clr_err,
  output logic [SIZESRSTAT-1:0] stat_out,
  output logic [SIZESRDYN-1:0]  dyn_out,
  output logic                  stat_valid,
  output logic                  dyn_valid,
  output logic                  busy,
  output logic                  frame_err
`ifdef STAT_CHECK_EN
  ,output logic                 stat_mismatch
`endif
);

  localparam int MAXSZ = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
  localparam int CNT_W = $clog2(MAXSZ + 1);
  localparam logic [CNT_W-1:0] STAT_LEN = CNT_W'(SIZESRSTAT);
  localparam logic [CNT_W-1:0] DYN_LEN  = CNT_W'(SIZESRDYN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RX_STAT, RX_DYN, WAIT} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SIZESRSTAT-1:0]   shstat_q, shstat_d;
  logic [SIZESRDYN-1:0]    shdyn_q, shdyn_d;
  logic [SIZESRSTAT-1:0]   stat_out_q;
  logic [SIZESRDYN-1:0]    dyn_out_q;
  logic                    stat_valid_q, dyn_valid_q, frame_err_q;
  logic                    err_d;
`ifdef STAT_CHECK_EN
  logic                    mismatch_q;
`endif

  // Shadow next values (MSB-first) and this cycle's error condition.
  always_comb begin
    shstat_d = {shstat_q[SIZESRSTAT-2:0], signal_in};
    shdyn_d  = {shdyn_q[SIZESRDYN-2:0], signal_in};
    err_d    = sel_stat & sel_dyn;
    if (state_q == RX_STAT) begin
      if (sel_stat && cnt_q == STAT_LEN) err_d = 1'b1;
      if (!sel_stat && cnt_q != STAT_LEN) err_d = 1'b1;
    end
    if (state_q == RX_DYN) begin
      if (sel_dyn && cnt_q == DYN_LEN) err_d = 1'b1;
      if (!sel_dyn && cnt_q != DYN_LEN) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shstat_q     <= '0;
      shdyn_q      <= '0;
      stat_out_q   <= '0;
      dyn_out_q    <= '0;
      stat_valid_q <= 1'b0;
      dyn_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef STAT_CHECK_EN
      mismatch_q   <= 1'b0;
`endif
    end else begin
      stat_valid_q <= 1'b0;
      dyn_valid_q  <= 1'b0;
      frame_err_q  <= err_d | (frame_err_q & ~clr_err);
      if (sel_stat && sel_dyn) begin
        state_q <= WAIT;
      end else begin
        case (state_q)
          IDLE: begin
            if (sel_stat) begin
              shstat_q <= shstat_d;
              cnt_q    <= CNT_ONE;
              state_q  <= RX_STAT;
            end else if (sel_dyn) begin
              shdyn_q <= shdyn_d;
              cnt_q   <= CNT_ONE;
              state_q <= RX_DYN;
            end
          end
          RX_STAT: begin
            if (sel_stat) begin
              if (cnt_q < STAT_LEN) begin
                shstat_q <= shstat_d;
                cnt_q    <= cnt_q + CNT_ONE;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              if (cnt_q == STAT_LEN) begin
                stat_out_q   <= shstat_q;
                stat_valid_q <= 1'b1;
`ifdef STAT_CHECK_EN
                mismatch_q   <= (shstat_q != STAT_EXPECTED);
`endif
              end
              // A same-cycle handover makes this bit the first dynamic bit.
              if (sel_dyn) begin
                shdyn_q <= shdyn_d;
                cnt_q   <= CNT_ONE;
                state_q <= RX_DYN;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          RX_DYN: begin
            if (sel_dyn) begin
              if (cnt_q < DYN_LEN) begin
                shdyn_q <= shdyn_d;
                cnt_q   <= cnt_q + CNT_ONE;
              end else begin
                state_q <= WAIT;
              end
            end else begin
              if (cnt_q == DYN_LEN) begin
                dyn_out_q   <= shdyn_q;
                dyn_valid_q <= 1'b1;
              end
              if (sel_stat) begin
                shstat_q <= shstat_d;
                cnt_q    <= CNT_ONE;
                state_q  <= RX_STAT;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: begin
            if (!sel_stat && !sel_dyn) state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign stat_out   = stat_out_q;
  assign dyn_out    = dyn_out_q;
  assign stat_valid = stat_valid_q;
  assign dyn_valid  = dyn_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);
`ifdef STAT_CHECK_EN
  assign stat_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_shiftreg_receiver.sv
// Bench for shiftreg_receiver: directed and random frames checked every cycle against a
// queue-based frame model.
module tb_shiftreg_receiver;
  localparam int SS = 88;
  localparam int SD = 16;
  localparam logic [87:0] REF = 88'hABCDEF123456789ABCDEF1;

  logic CLK = 1'b0;
  logic RST, signal_in, sel_stat, sel_dyn, clr_err;
  logic [SS-1:0] stat_out;
  logic [SD-1:0] dyn_out;
  logic stat_valid, dyn_valid, busy, frame_err;
`ifdef STAT_CHECK_EN
  logic stat_mismatch;
`endif

  shiftreg_receiver dut (
    .CLK(CLK), .RST(RST), .signal_in(signal_in), .sel_stat(sel_stat), .sel_dyn(sel_dyn),
    .clr_err(clr_err), .stat_out(stat_out), .dyn_out(dyn_out), .stat_valid(stat_valid),
    .dyn_valid(dyn_valid), .busy(busy), .frame_err(frame_err)
`ifdef STAT_CHECK_EN
    , .stat_mismatch(stat_mismatch)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Model: seg 0=idle, 1=static frame, 2=dynamic frame, 3=waiting for selects low.
  int            seg;
  bit            q[$];
  logic [SS-1:0] m_stat;
  logic [SD-1:0] m_dyn;
  bit            m_sv, m_dv, m_err, m_mis;

  function automatic logic [127:0] pack_q();
    logic [127:0] w = '0;
    foreach (q[i]) w = {w[126:0], 1'(q[i])};
    return w;
  endfunction

  task automatic model_reset();
    seg = 0; q.delete();
    m_stat = '0; m_dyn = '0; m_sv = 0; m_dv = 0; m_err = 0; m_mis = 0;
  endtask

  task automatic model_step(bit s, bit d, bit b, bit c);
    bit err = 0;
    m_sv = 0; m_dv = 0;
    if (s && d) begin
      err = 1; seg = 3; q.delete();
    end else if (seg == 3) begin
      if (!s && !d) seg = 0;
    end else if (seg == 0) begin
      if (s) begin q = {b}; seg = 1; end
      else if (d) begin q = {b}; seg = 2; end
    end else if ((seg == 1 && s) || (seg == 2 && d)) begin
      if (q.size() < ((seg == 1) ? SS : SD)) q.push_back(b);
      else begin err = 1; seg = 3; q.delete(); end
    end else begin
      if (seg == 1) begin
        if (q.size() == SS) begin
          m_stat = SS'(pack_q()); m_sv = 1; m_mis = (m_stat != REF);
        end else err = 1;
      end else begin
        if (q.size() == SD) begin m_dyn = SD'(pack_q()); m_dv = 1; end
        else err = 1;
      end
      q.delete();
      if (d) begin q = {b}; seg = 2; end
      else if (s) begin q = {b}; seg = 1; end
      else seg = 0;
    end
    m_err = err | (m_err & !c);
  endtask

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stat_out", 128'(stat_out), 128'(m_stat));
    chk("dyn_out", 128'(dyn_out), 128'(m_dyn));
    chk("stat_valid", 128'(stat_valid), 128'(m_sv));
    chk("dyn_valid", 128'(dyn_valid), 128'(m_dv));
    chk("busy", 128'(busy), 128'(seg != 0));
    chk("frame_err", 128'(frame_err), 128'(m_err));
`ifdef STAT_CHECK_EN
    chk("stat_mismatch", 128'(stat_mismatch), 128'(m_mis));
`endif
  endtask

  task automatic step(bit s, bit d, bit b, bit c);
    sel_stat = s; sel_dyn = d; signal_in = b; clr_err = c;
    @(posedge CLK);
    model_step(s, d, b, c);
    #1 check_all();
  endtask

  task automatic send(bit s, bit d, logic [127:0] w, int n);
    for (int i = 0; i < n; i++) step(s, d, w[n-1-i], 1'b0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 RST = 1'b0;
  endtask

  function automatic logic [127:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    RST = 1'b1; signal_in = 0; sel_stat = 0; sel_dyn = 0; clr_err = 0;
    model_reset();
    #12 check_all();
    RST = 1'b0;
    step(0, 0, 0, 0);

    // Reference static frame.
    send(1, 0, 128'(REF), SS);
    step(0, 0, 0, 0);
    chk("ref_word", 128'(stat_out), 128'(REF));
    chk("ref_valid", 128'(stat_valid), 128'(1));
    step(0, 0, 0, 0);

    // Static frame with handover to dynamic 16'h1234.
    send(1, 0, rnd_word(), SS);
    send(0, 1, 128'h1234, SD);
    step(0, 0, 0, 0);
    chk("dyn_1234", 128'(dyn_out), 128'h1234);

    // Short static frame, then clear.
    send(1, 0, rnd_word(), 10);
    step(0, 0, 0, 0);
    chk("short_err", 128'(frame_err), 128'(1));
    step(0, 0, 0, 1);
    chk("clr_err", 128'(frame_err), 128'(0));

    // Overlong dynamic frame.
    send(0, 1, rnd_word(), 17);
    step(0, 0, 0, 0);

    // Both selects high mid static frame, then clean dynamic frame.
    send(1, 0, rnd_word(), 30);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    send(0, 1, 128'hBEEF, SD);
    step(0, 0, 0, 1);
    chk("dyn_beef", 128'(dyn_out), 128'hBEEF);

    // Reset in the middle of a static frame, then recover.
    send(1, 0, 128'(REF), 40);
    pulse_reset();
    send(1, 0, 128'(REF), SS);
    step(0, 0, 0, 0);
    chk("recover", 128'(stat_out), 128'(REF));

`ifdef STAT_CHECK_EN
    send(1, 0, 128'h0, SS);
    step(0, 0, 0, 0);
    chk("mis_zero", 128'(stat_mismatch), 128'(1));
    send(1, 0, 128'(REF), SS);
    step(0, 0, 0, 0);
    chk("mis_ref", 128'(stat_mismatch), 128'(0));
`endif

    // Random frames: random kind, occasional length error, handover, collisions, clears.
    for (int it = 0; it < 40; it++) begin
      bit isdyn = 1'($urandom_range(0, 1));
      int len = (isdyn ? SD : SS);
      int r = $urandom_range(0, 7);
      if (r == 0) len = len - 1 - $urandom_range(0, 5);
      else if (r == 1) len = len + 1;
      send(!isdyn, isdyn, rnd_word(), len);
      if ($urandom_range(0, 9) == 0) step(1, 1, 1'($urandom), 0);
      if ($urandom_range(0, 2) != 0) begin
        for (int g = 0; g <= $urandom_range(0, 2); g++)
          step(0, 0, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
